fpu_cmd_seq: RTL

- Initiator-side sequencer for the FP16 FPU datapath.
- Accepts tagged FP16 commands over a valid/ready interface and drives the FPU operand/op inputs from registers.
- Waits a programmable number of cycles, then captures the FPU result and condition codes.
- Returns them over a valid/ready response interface; rejects ops the FPU does not yet implement with an error response.

---
 rtl/fpu_cmd_seq_pkg.sv | 35 +++
 rtl/fpu_cmd_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fpu_cmd_seq_pkg.sv
// rtl/fpu_cmd_seq_pkg.sv - shared types and helpers for the FP16 FPU command sequencer
package fpu_cmd_seq_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_DIV = 3'd3,
        FPU_SHL = 3'd4,
        FPU_SHR = 3'd5
    } fpuOp_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic nan;
        logic inf;
    } condCode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seqState_t;

    localparam fp16_t FP16_QNAN = 16'h7E00;

    // Single place to enable an op once the FPU implements it.
    function automatic logic isSupportedOp(input fpuOp_t op);
        return (op == FPU_ADD) || (op == FPU_SUB);
    endfunction

endpackage

// File: rtl/fpu_cmd_seq.sv
// rtl/fpu_cmd_seq.sv - sequences one tagged FP16 command at a time through the FPU
module fpu_cmd_seq
    import fpu_cmd_seq_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  fpuOp_t           cmdOp,
    input  fp16_t            cmdA,
    input  fp16_t            cmdB,
    input  logic [TAG_W-1:0] cmdTag,
    output logic             rspValid,
    input  logic             rspReady,
    output fp16_t            rspResult,
    output condCode_t        rspCond,
    output logic [TAG_W-1:0] rspTag,
    output logic             rspErr,
    output fp16_t            fpuIn1,
    output fp16_t            fpuIn2,
    output fpuOp_t           fpuOp,
    input  fp16_t            fpuOut,
    input  condCode_t        fpuCond,
    output logic [15:0]      doneCount
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    seqState_t        state;
    seqState_t        nextState;
    logic [CNT_W-1:0] counter;
    logic [TAG_W-1:0] tagReg;
    logic             accept;
    logic             rspFire;

    assign rspValid = (state == RESP);
    assign accept   = cmdValid & cmdReady;
    assign rspFire  = rspValid & rspReady;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        cmdReady  = 1'b0;
        case (state)
            IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) begin
                    nextState = isSupportedOp(cmdOp) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (counter == '0) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                // A new command may only enter as the current response leaves.
                cmdReady = rspReady;
                if (rspReady) begin
                    if (cmdValid) begin
                        nextState = isSupportedOp(cmdOp) ? ISSUE : RESP;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            fpuIn1    <= '0;
            fpuIn2    <= '0;
            fpuOp     <= FPU_ADD;
            tagReg    <= '0;
            counter   <= '0;
            rspResult <= '0;
            rspCond   <= '0;
            rspTag    <= '0;
            rspErr    <= 1'b0;
            doneCount <= '0;
        end else begin
            if (accept) begin
                fpuIn1 <= cmdA;
                fpuIn2 <= cmdB;
                fpuOp  <= cmdOp;
                tagReg <= cmdTag;
                if (isSupportedOp(cmdOp)) begin
                    counter <= CNT_W'(LATENCY - 1);
                end else begin
                    rspResult <= FP16_QNAN;
                    rspCond   <= '0;
                    rspTag    <= cmdTag;
                    rspErr    <= 1'b1;
                end
            end else if (state == ISSUE) begin
                if (counter != '0) begin
                    counter <= counter - CNT_W'(1);
                end else begin
                    rspResult <= fpuOut;
                    rspCond   <= fpuCond;
                    rspTag    <= tagReg;
                    rspErr    <= 1'b0;
                end
            end
            if (rspFire) begin
                doneCount <= doneCount + 16'd1;
            end
        end
    end

endmodule
